ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
- PS/2 keyboard receiver for the 8088 DE0 system, clocked from the 25 MHz CPU clock domain.
- Deglitches the PS2_CLK/PS2_DAT pins and deserialises 11-bit device-to-host frames.
- Buffers received scan codes in a show-ahead FIFO for the core's port-60h read path.
- Receive-only: the host never drives PS2_CLK or PS2_DAT. The top level ties both pins to input / Z.

Parameters:
- FILTER, 4: consecutive identical synchronised samples needed to accept a new ps2_clk level.
- TIMEOUT, 25000: clock cycles with no accepted falling edge mid-frame before the frame is aborted (1 ms at 25 MHz).
- FIFO_AW, 3: FIFO address width; depth = 2^FIFO_AW = 8 bytes.

Ports:
- clock, input, 1: system clock (25 MHz).
- resetn, input, 1: asynchronous active-low reset.
- ps2_clk, input, 1: raw PS/2 clock pin, asynchronous.
- ps2_dat, input, 1: raw PS/2 data pin, asynchronous.
- rd, input, 1: pop strobe, one cycle per byte.
- clr_err, input, 1: clears the sticky error flags.
- dout, output, 8: FIFO head byte, valid while ready=1.
- ready, output, 1: FIFO not empty.
- overflow, output, 1: sticky; a completed byte was dropped because the FIFO was full.
- parity_err, output, 1: sticky; a frame was rejected for parity or stop-bit error.

Behaviour:
- Reset (async, resetn=0):
  - dout=0, ready=0, overflow=0, parity_err=0.
  - FIFO empty, bit counter 0, state IDLE, timeout counter 0.
  - Filter registers = 1 (bus idle high).
- Input conditioning:
  - Two-flop synchronisers on both pins.
  - Filtered clock clk_f changes only after FILTER consecutive equal synchronised samples.
  - Pulses shorter than FILTER cycles are ignored.
  - fall = clk_f was 1 last cycle and is 0 this cycle.
  - Data is sampled from the synchronised ps2_dat in the cycle fall is asserted.
- FSM states: IDLE, RECV, CHECK.
  - IDLE: on fall, if data=0 (start bit) go to RECV with bitcnt=1. If data=1 stay in IDLE and discard.
  - RECV: on each fall, shift data in. Bits 1..8 are data (LSB first), bit 9 is parity, bit 10 is stop. After bit 10 go to CHECK.
  - RECV: timeout counter clears on every fall and otherwise increments. When it reaches TIMEOUT, return to IDLE, bitcnt=0, partial byte discarded, no flag set.
  - CHECK (one cycle): frame is valid when XOR of the 8 data bits and the parity bit = 1 (odd) and stop=1.
    - Valid: push the byte.
    - Invalid: set parity_err and push nothing.
    - Always return to IDLE.
- Latency: ready=1 and dout=byte on the cycle after CHECK, i.e. 2 clocks after the stop-bit fall.
- FIFO:
  - Show-ahead: dout always presents the head byte; dout holds its last value when empty.
  - rd while ready=1 pops; the next byte (or ready=0) appears the following cycle.
  - rd while ready=0 is ignored; no underflow.
  - Push is accepted when the FIFO is not full, or when a pop occurs in the same cycle. Simultaneous push and pop leave the count unchanged.
  - Push while full with no pop: byte dropped, overflow set, FIFO contents unchanged.
  - Pointers wrap modulo 2^FIFO_AW. The count is FIFO_AW+1 bits wide.
- Sticky flags: clr_err clears both flags. If a set event and clr_err coincide, set wins.
- Reset mid-frame: all state is discarded immediately. After release the block waits in IDLE for the next start bit.

Test Plan:
- Use FILTER=4, TIMEOUT=400, PS/2 half-period of 40 cycles.
- Basic receive: send 0x1C with parity=0 and stop=1 -> ready=1 and dout=0x1C exactly 2 clocks after the stop fall. One-cycle rd -> ready=0 next cycle. Flags stay 0.
- Bad parity: send 0x1C with parity=1 -> ready stays 0, parity_err=1. Pulse clr_err -> parity_err=0. Then send 0x5A with parity=1 -> dout=0x5A.
- Overflow and wrap:
  - Send bytes 0x01..0x09 with no reads -> overflow=1.
  - Nine rd pulses -> dout sequence 0x01..0x08, then ready=0; 0x09 is lost.
  - Then send 0x0A, read it, and repeat 10 times to exercise pointer wrap.
- Simultaneous push and pop:
  - Fill the FIFO to 8 entries, then assert rd in the same cycle as CHECK of 0x33.
  - Required: overflow=0, count stays 8, and the last byte read out is 0x33.
- Glitch and timeout:
  - A 2-cycle low pulse on ps2_clk in IDLE -> no state change.
  - Send a start bit plus 4 data bits, then idle for 500 cycles, then a full 0xF0 frame -> only 0xF0 is received, flags 0.
- Reset mid-frame: drop resetn for 3 cycles after 5 bits of a frame -> all outputs return to 0. A following 0x5A frame -> ready=1, dout=0x5A, and a single rd empties the FIFO.

Source files
------------

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises and deglitches the pins, deserialises
// 11-bit device-to-host frames and queues valid scan codes in a show-ahead FIFO.
module ps2_keyboard #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 25000,
    parameter int FIFO_AW = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] dout,
    output logic       ready,
    output logic       overflow,
    output logic       parity_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FW    = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [FW-1:0] r_fcnt;
    logic          r_clk_f, r_clk_f_d;
    logic          w_fall;

    state_t        r_state;
    logic [3:0]    r_bitcnt;
    logic [TW-1:0] r_tocnt;
    logic [9:0]    r_shift;

    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [7:0]       r_dout;
    logic             r_overflow, r_parity_err;

    logic w_check, w_frame_ok, w_push, w_pop, w_full, w_push_ok, w_drop;

    // Pin synchronisers and clock filter; idle bus is high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_fcnt    <= '0;
            r_clk_f   <= 1'b1;
            r_clk_f_d <= 1'b1;
        end else begin
            r_clk_s1  <= ps2_clk;
            r_clk_s2  <= r_clk_s1;
            r_dat_s1  <= ps2_dat;
            r_dat_s2  <= r_dat_s1;
            r_clk_f_d <= r_clk_f;
            if (r_clk_s2 == r_clk_f) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FW'(FILTER - 1)) begin
                r_clk_f <= r_clk_s2;
                r_fcnt  <= '0;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end

    assign w_fall = r_clk_f_d & ~r_clk_f;

    // Frame state machine; r_bitcnt holds the index of the next bit expected.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_tocnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tocnt <= '0;
                    if (w_fall && !r_dat_s2) begin
                        r_state  <= S_RECV;
                        r_bitcnt <= 4'd1;
                    end
                end
                S_RECV: begin
                    if (w_fall) begin
                        r_tocnt <= '0;
                        if (r_bitcnt == 4'd10) begin
                            r_state  <= S_CHECK;
                            r_bitcnt <= '0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end else if (r_tocnt == TW'(TIMEOUT - 1)) begin
                        r_state  <= S_IDLE;
                        r_bitcnt <= '0;
                        r_tocnt  <= '0;
                    end else begin
                        r_tocnt <= r_tocnt + TW'(1);
                    end
                end
                S_CHECK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_bitcnt <= '0;
                    r_tocnt  <= '0;
                end
            endcase
        end
    end

    // LSB-first shift: after the stop bit, [7:0]=data, [8]=parity, [9]=stop.
    always_ff @(posedge clock) begin
        if (r_state == S_RECV && w_fall) begin
            r_shift <= {r_dat_s2, r_shift[9:1]};
        end
    end

    assign w_check    = (r_state == S_CHECK);
    assign w_frame_ok = (^r_shift[8:0]) & r_shift[9];
    assign w_push     = w_check & w_frame_ok;
    assign w_pop      = rd & (r_count != '0);
    assign w_full     = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_push_ok  = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & w_full & ~w_pop;

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_shift[7:0];
        end
    end

    // dout is a register so it can hold the last byte once the FIFO drains.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                if (r_count > (FIFO_AW+1)'(1)) begin
                    r_dout <= r_mem[r_rptr + FIFO_AW'(1)];
                end else if (w_push_ok) begin
                    r_dout <= r_shift[7:0];
                end
            end else if (w_push_ok && r_count == '0) begin
                r_dout <= r_shift[7:0];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_check && !w_frame_ok) begin
                r_parity_err <= 1'b1;
            end else if (clr_err) begin
                r_parity_err <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign ready      = (r_count != '0);
    assign overflow   = r_overflow;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: directed table, multi-cycle corner sequences and a
// randomized run checked against a queue-based model of the receiver.
module tb_ps2_keyboard;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 400;
    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic       clock = 1'b0;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       rd;
    logic       clr_err;
    logic [7:0] dout;
    logic       ready;
    logic       overflow;
    logic       parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic       m_ovf;
    logic       m_perr;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_ready;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[8];

    ps2_keyboard #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_AW(FIFO_AW)) dut (
        .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .rd(rd), .clr_err(clr_err), .dout(dout), .ready(ready),
        .overflow(overflow), .parity_err(parity_err)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // mode 0: plain; mode 1: check 2-clock latency after stop fall (FIFO empty);
    // mode 2: assert rd during the CHECK cycle of this frame.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input int mode);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            repeat (20) tick();
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                // Stop fall is seen 2+FILTER edges after the pin drops.
                repeat (2 + FILTER + 1) tick();
                check("latency_not_early", ready, 0);
                tick();
                check("latency_ready", ready, 1);
                check("latency_dout", dout, d);
                repeat (40 - (2 + FILTER + 2)) tick();
            end else if (i == 10 && mode == 2) begin
                repeat (2 + FILTER + 1) tick();
                rd = 1'b1;
                tick();
                rd = 1'b0;
                repeat (40 - (2 + FILTER + 2)) tick();
            end else begin
                repeat (40) tick();
            end
            ps2_clk = 1'b1;
            repeat (20) tick();
        end
        ps2_dat = 1'b1;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // Model: frame valid iff odd parity over data+parity and stop=1.
    task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
        if (((^d) ^ par) && stop) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovf = 1'b1;
        end else begin
            m_perr = 1'b1;
        end
    endtask

    task automatic model_read();
        check("rnd_ready", ready, (q.size() != 0));
        if (q.size() != 0) begin
            check("rnd_dout", dout, q[0]);
            void'(q.pop_front());
        end
        pulse_rd();
    endtask

    initial begin
        logic [7:0] d;
        logic       good;
        logic       par;

        resetn  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        rd      = 1'b0;
        clr_err = 1'b0;
        repeat (3) tick();
        check("reset_dout", dout, 0);
        check("reset_ready", ready, 0);
        check("reset_ovf", overflow, 0);
        check("reset_perr", parity_err, 0);
        resetn = 1'b1;
        repeat (5) tick();

        // Basic receive with latency check.
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1);
        pulse_rd();
        check("basic_ready_after_rd", ready, 0);
        check("basic_ovf", overflow, 0);
        check("basic_perr", parity_err, 0);

        // Bad parity then recovery.
        send_frame(8'h1C, 1'b1, 1'b1, 11, 0);
        check("badpar_ready", ready, 0);
        check("badpar_perr", parity_err, 1);
        pulse_clr();
        check("badpar_clr", parity_err, 0);
        send_frame(8'h5A, 1'b1, 1'b1, 11, 0);
        check("badpar_5a_ready", ready, 1);
        check("badpar_5a_dout", dout, 8'h5A);
        pulse_rd();

        // Table-driven single frames from an empty FIFO.
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 11, 0);
            check($sformatf("tbl%0d_ready", i), ready, vecs[i].exp_ready);
            check($sformatf("tbl%0d_perr", i), parity_err, vecs[i].exp_perr);
            if (vecs[i].exp_ready) begin
                check($sformatf("tbl%0d_dout", i), dout, vecs[i].data);
                pulse_rd();
                check($sformatf("tbl%0d_empty", i), ready, 0);
            end
            pulse_clr();
            check($sformatf("tbl%0d_perr_clr", i), parity_err, 0);
        end

        // Overflow: nine bytes into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) begin
            d = 8'(i);
            send_frame(d, ~^d, 1'b1, 11, 0);
            if (i == 8) check("ovf_not_yet", overflow, 0);
        end
        check("ovf_set", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_rd%0d_ready", i), ready, 1);
            check($sformatf("ovf_rd%0d_dout", i), dout, 8'(i));
            pulse_rd();
        end
        check("ovf_drained", ready, 0);
        pulse_rd();
        check("ovf_underflow_ready", ready, 0);
        check("ovf_hold_dout", dout, 8'h08);
        check("ovf_sticky", overflow, 1);
        pulse_clr();
        check("ovf_clr", overflow, 0);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) begin
            d = 8'h0A + 8'(i);
            send_frame(d, ~^d, 1'b1, 11, 0);
            check($sformatf("wrap%0d_dout", i), dout, d);
            pulse_rd();
            check($sformatf("wrap%0d_empty", i), ready, 0);
        end

        // Push and pop coincide on a full FIFO.
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'h20 + 8'(i);
            send_frame(d, ~^d, 1'b1, 11, 0);
        end
        send_frame(8'h33, ~^8'h33, 1'b1, 11, 2);
        check("simul_ovf", overflow, 0);
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("simul_rd%0d", i), dout, 8'h20 + 8'(i));
            pulse_rd();
        end
        check("simul_last_ready", ready, 1);
        check("simul_last_dout", dout, 8'h33);
        pulse_rd();
        check("simul_empty", ready, 0);

        // Two-cycle glitch with data low must not start a frame.
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (2) tick();
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (100) tick();
        check("glitch_ready", ready, 0);
        send_frame(8'h6B, ~^8'h6B, 1'b1, 11, 0);
        check("glitch_dout", dout, 8'h6B);
        check("glitch_perr", parity_err, 0);
        pulse_rd();

        // Truncated frame times out.
        send_frame(8'h0F, 1'b0, 1'b1, 5, 0);
        repeat (500) tick();
        check("timeout_ready", ready, 0);
        send_frame(8'hF0, 1'b1, 1'b1, 11, 0);
        check("timeout_ready_f0", ready, 1);
        check("timeout_dout", dout, 8'hF0);
        check("timeout_perr", parity_err, 0);
        check("timeout_ovf", overflow, 0);
        pulse_rd();
        check("timeout_empty", ready, 0);

        // Reset in the middle of a frame.
        send_frame(8'h11, 1'b0, 1'b1, 11, 0);
        send_frame(8'h22, 1'b1, 1'b1, 11, 0);
        check("pre_rst_perr", parity_err, 1);
        check("pre_rst_ready", ready, 1);
        send_frame(8'h77, 1'b0, 1'b1, 5, 0);
        resetn = 1'b0;
        #1;
        check("rst_async_ready", ready, 0);
        repeat (3) tick();
        check("rst_dout", dout, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ovf", overflow, 0);
        resetn = 1'b1;
        repeat (5) tick();
        send_frame(8'h5A, 1'b1, 1'b1, 11, 0);
        check("post_rst_ready", ready, 1);
        check("post_rst_dout", dout, 8'h5A);
        pulse_rd();
        check("post_rst_empty", ready, 0);

        // Randomized frames and reads against the model.
        q.delete();
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        for (int it = 0; it < 24; it++) begin
            d    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            par  = good ? ~^d : ^d;
            send_frame(d, par, 1'b1, 11, 0);
            model_frame(d, par, 1'b1);
            check("rnd_perr", parity_err, m_perr);
            check("rnd_ovf", overflow, m_ovf);
            for (int r = 0; r < int'($urandom_range(0, 1)); r++) begin
                model_read();
            end
            if ($urandom_range(0, 5) == 0) begin
                pulse_clr();
                m_ovf  = 1'b0;
                m_perr = 1'b0;
            end
        end
        while (q.size() != 0) model_read();
        check("rnd_final_ready", ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
